// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//   Request/result bundle for the bit-serial subtractor.
//   master : drives start/a/b, observes busy/done/diff/borrow
//   slave  : the subtractor itself
//   Signals:
//     start  request, accepted only while busy is low
//     a, b   minuend / subtrahend, sampled on the accepted start cycle
//     busy   operation in flight (RUN and DONE cycles)
//     done   one-cycle pulse, diff/borrow valid and held afterwards
//     diff   a - b modulo 2^WIDTH
//     borrow 1 iff a < b (unsigned)
//   Optional (SERIAL_SUB_FLAGS_EN defined): zero, ovf result flags.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             zero;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, zero, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, zero, ovf
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor. diff = a - b is formed LSB first,
//   one bit per clock, through a single full-adder cell evaluating a + ~b + 1
//   with a registered carry. One operation takes WIDTH+2 cycles including the
//   accept cycle and the DONE cycle.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset (aborts any operation in flight)
//     bus   serial_subtractor_if.slave : start, a, b in; busy, done, diff,
//           borrow out (plus zero, ovf when flags are enabled)
//
//   Parameter WIDTH must match the WIDTH of the connected interface (>= 2).
//
//   Build option: define SERIAL_SUB_FLAGS_EN to add the zero and ovf result
//   flags; they update on the DONE cycle together with diff.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             s_bit;
    logic             c_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] res_nxt;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Full-adder cell: the subtrahend is stored inverted and carry starts at 1,
    // so the ripple through time computes a + ~b + 1.
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nxt    = majority(a_sh[0], b_sh[0], carry);
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign res_nxt  = {s_bit, res_sh[WIDTH-1:1]};

    // ---------------- control: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- control: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath: shift registers and result ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= ~bus.b;
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= res_nxt;
                    carry  <= c_nxt;
                    cnt    <= cnt + 1'b1;
                    // Publish on the final bit so diff/borrow are valid in DONE
                    // and stay untouched through the next operation's RUN.
                    if (last_bit) begin
                        diff_q   <= res_nxt;
                        borrow_q <= ~c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    // Operand sign bits are shifted out of a_sh/b_sh, so keep them for ovf.
    logic a_msb;
    logic b_msb;
    logic zero_q;
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                a_msb <= bus.a[WIDTH-1];
                b_msb <= bus.b[WIDTH-1];
            end
            if (state == RUN && last_bit) begin
                zero_q <= (res_nxt == '0);
                // s_bit is the result MSB on the final bit.
                ovf_q  <= (a_msb != b_msb) && (s_bit != a_msb);
            end
        end
    end

    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
`endif

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor. The driver decides acceptance from
//   its own model of operation timing and pushes the arithmetic result of each
//   accepted op; a negedge monitor checks busy, done timing and the held
//   diff/borrow(/flags) every cycle. A second 16-bit instance runs one
//   directed operation.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst16;

    serial_subtractor_if #(.WIDTH(W))  bus ();
    serial_subtractor_if #(.WIDTH(16)) bus16 ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (bus16)
    );

    int   cyc = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int           acc;
        int           fin;
        bit           aborted;
        logic [W-1:0] diff;
        logic         brw;
        logic         zf;
        logic         of;
    } op_t;

    op_t q[$];

    logic [W-1:0] held_diff = '0;
    logic         held_brw  = 1'b0;
    logic         held_z    = 1'b0;
    logic         held_o    = 1'b0;
    int           n_acc     = 0;
    logic         busy_exp;
    logic         done_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference result straight from the arithmetic definition.
    function automatic op_t model(input int acc, input logic [W-1:0] aa, input logic [W-1:0] bb);
        op_t o;
        int  sa;
        int  sb;
        int  sd;
        o.acc     = acc;
        o.fin     = acc + W;
        o.aborted = 1'b0;
        o.diff    = aa - bb;
        o.brw     = (aa < bb);
        o.zf      = (aa == bb);
        sa        = int'($signed(aa));
        sb        = int'($signed(bb));
        sd        = sa - sb;
        o.of      = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        return o;
    endfunction

    // Drives inputs for the next rising edge (edge number cyc+1).
    task automatic drive(input logic st, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic r);
        @(posedge clk);
        #1;
        bus.start = st;
        bus.a     = aa;
        bus.b     = bb;
        rst       = r;
        if (r) begin
            foreach (q[i]) begin
                if (q[i].fin >= cyc + 1) begin
                    q[i].aborted = 1'b1;
                    q[i].fin     = cyc;
                end
            end
        end else if (st && (q.size() == 0 || q[$].fin < cyc)) begin
            q.push_back(model(cyc + 1, aa, bb));
            n_acc++;
        end
    endtask

    // Monitor: cycle number cyc = edges seen so far.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (rst_seen) begin
                held_diff = '0;
                held_brw  = 1'b0;
                held_z    = 1'b0;
                held_o    = 1'b0;
            end
            while (q.size() > 0 && q[0].aborted && q[0].fin < cyc) q.delete(0);
            busy_exp = (q.size() > 0) && (q[0].acc <= cyc) && (cyc <= q[0].fin);
            done_exp = (q.size() > 0) && !q[0].aborted && (q[0].fin == cyc);
            check("busy", 32'(bus.busy), 32'(busy_exp));
            check("done", 32'(bus.done), 32'(done_exp));
            if (done_exp) begin
                held_diff = q[0].diff;
                held_brw  = q[0].brw;
                held_z    = q[0].zf;
                held_o    = q[0].of;
                q.delete(0);
            end
            check("diff", 32'(bus.diff), 32'(held_diff));
            check("borrow", 32'(bus.borrow), 32'(held_brw));
`ifdef SERIAL_SUB_FLAGS_EN
            check("zero", 32'(bus.zero), 32'(held_z));
            check("ovf", 32'(bus.ovf), 32'(held_o));
`endif
        end
    end

    // Directed 16-bit operation on the second instance.
    int e16;
    initial begin
        rst16       = 1'b1;
        bus16.start = 1'b0;
        bus16.a     = '0;
        bus16.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst16       = 1'b0;
        bus16.start = 1'b1;
        bus16.a     = 16'h1234;
        bus16.b     = 16'h0235;
        e16         = cyc + 1;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus16.done) break;
        end
        check("done16_cycle", 32'(cyc), 32'(e16 + 16));
        check("diff16", 32'(bus16.diff), 32'h0FFF);
        check("borrow16", 32'(bus16.borrow), 32'h0);
        check("busy16", 32'(bus16.busy), 32'h1);
    end

    // Main stimulus.
    int base;
    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // reset for two cycles
        drive(1'b0, 8'd0, 8'd0, 1'b1);
        drive(1'b0, 8'd0, 8'd0, 1'b1);

        // basic subtraction and arithmetic corners
        drive(1'b1, 8'd100, 8'd37, 1'b0);
        repeat (11) drive(1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 8'd5, 8'd9, 1'b0);
        repeat (11) drive(1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 8'h80, 8'h01, 1'b0);
        repeat (11) drive(1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 8'h5A, 8'h5A, 1'b0);
        repeat (11) drive(1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 8'h00, 8'h01, 1'b0);
        repeat (11) drive(1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 8'hC3, 8'h00, 1'b0);
        repeat (11) drive(1'b0, 8'd0, 8'd0, 1'b0);

        // start while busy must be ignored
        drive(1'b1, 8'd77, 8'd20, 1'b0);
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 8'd0, 8'd0, 1'b0);
        repeat (11) drive(1'b0, 8'd0, 8'd0, 1'b0);

        // reset mid-operation, then an immediate new op
        drive(1'b1, 8'd200, 8'd13, 1'b0);
        repeat (3) drive(1'b0, 8'd0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 8'd0, 1'b1);
        drive(1'b1, 8'd9, 8'd4, 1'b0);
        repeat (11) drive(1'b0, 8'd0, 8'd0, 1'b0);

        // start held high for three back-to-back ops: a = 1, 2, 3; b = 0
        base = n_acc;
        for (int k = 0; k < 40 && n_acc < base + 3; k++) begin
            drive(1'b1, 8'(n_acc - base + 1), 8'd0, 1'b0);
        end
        repeat (11) drive(1'b0, 8'd0, 8'd0, 1'b0);

        // randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = ra;
                1:       rb = '0;
                default: ;
            endcase
            rs = ($urandom_range(0, 79) == 0);
            drive(($urandom_range(0, 2) == 0), ra, rb, rs);
        end
        repeat (14) drive(1'b0, 8'd0, 8'd0, 1'b0);

        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("ops_accepted_min", 32'(n_acc > 12), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
